calc_controller: RTL and testbench
==================================

# calc_controller

Sequencing controller for the signed 3-bit add/sub calculator datapath. It collects two 3-bit two's-complement operands and an operation from switch inputs under a debounced enter button. It then drives the combinational `add_sub` datapath, captures its 4-bit signed result and holds it for the display stage. It sits between the board input logic and `add_sub`, and is the only block that drives the datapath's A, B and M inputs.

## Interface
Parameters:
- `CNT_W`, default 8: width of the completed-operation counter.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sw_val` in 3: operand value, two's complement, range -4..3.
- `sw_op` in 1: operation select; 0 = add, 1 = subtract. Sampled with operand B.
- `btn_enter` in 1: debounced enter level; may stay high for many cycles.
- `btn_clear` in 1: debounced clear level.
- `dp_a` out 3: registered operand A to the datapath.
- `dp_b` out 3: registered operand B to the datapath.
- `dp_m` out 1: registered mode to the datapath.
- `dp_result` in 4: datapath signed result, combinational from `dp_a`/`dp_b`/`dp_m`.
- `res_q` out 4: captured signed result.
- `res_valid` out 1: high while `res_q` holds a fresh result.
- `busy` out 1: high during the execute cycle.
- `state_o` out 2: current state code, for the display stage.
- `op_cnt` out CNT_W: count of completed operations.
- `chain_err` out 1: chain rejection flag; tied 0 when chaining is compiled out.

## Operation
- Enter event: `enter_rise = btn_enter & ~btn_enter_q`.
  - `btn_enter_q` is a register; reset value 0.
  - A held button produces exactly one event.
- States and codes:
  - S_A = 0: wait for operand A.
  - S_B = 1: wait for operand B and the operation.
  - S_EXEC = 2: drive the datapath.
  - S_SHOW = 3: hold the result.
- Transitions:
  - S_A + enter: `dp_a <= sw_val`; clear `res_valid`; go to S_B.
  - S_B + enter: `dp_b <= sw_val`, `dp_m <= sw_op`; go to S_EXEC.
  - S_EXEC: always go to S_SHOW; `res_q <= dp_result`, `res_valid <= 1`, `op_cnt <= op_cnt + 1`.
  - S_SHOW + enter: go to S_A. `res_q` and `res_valid` are held until the next operand-A entry.
- Ignored events:
  - Enter during S_EXEC is ignored.
  - Enter arriving in the same cycle as the S_EXEC→S_SHOW transition is evaluated in S_EXEC, so it is ignored.
- Clear:
  - A `btn_clear` level, sampled on any edge, forces S_A.
  - It zeroes `dp_a`, `dp_b`, `dp_m`, `res_q`, `res_valid`, `op_cnt` and `chain_err`.
  - Clear has priority over enter.
  - Clear is not edge-detected: holding it holds the block cleared.
- Arithmetic:
  - Operands are 3-bit signed.
  - The result is 4-bit signed: add gives -8..6, subtract gives -7..7.
  - The controller never modifies `dp_result`.
- `op_cnt` wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values:
  - State S_A.
  - `dp_a`, `dp_b`, `dp_m`, `res_q`, `res_valid`, `busy`, `chain_err` and `op_cnt` all 0.
  - `btn_enter_q` 0.
- `state_o` and `busy` are decoded from the state register and are glitch-free relative to `clk`. `busy` = (state == S_EXEC).
- Latency: operand-B enter sampled at edge k:
  - S_EXEC during cycle k..k+1.
  - Result captured at edge k+1.
  - `res_valid` high from edge k+1.
- Datapath settling: the datapath has one full clock period to settle. `dp_*` change only on edges that enter S_B or S_EXEC, or on clear.
- Reset or clear while in S_EXEC: no capture, `op_cnt` not incremented, state S_A on the next cycle.

## Configuration
- `CALC_CHAIN_EN` defined: enter in S_SHOW chains the result into the next operation.
  - If `res_q` is in -4..3 (bits 3 and 2 equal): `dp_a <= res_q[2:0]`, clear `res_valid`, go to S_B.
  - Otherwise: set `chain_err` and go to S_A. `chain_err` clears on the next operand-A entry, on clear, or on reset.
- `CALC_CHAIN_EN` undefined: enter in S_SHOW always goes to S_A, and `chain_err` is constant 0.

## Test plan
- Add: A=3, B=2 with `sw_op`=0 → `res_q`=4'b0101 one edge after S_EXEC; `res_valid`=1; `op_cnt`=1.
- Subtract and negative sum:
  - A=1, B=-2 (3'b110), `sw_op`=1 → `res_q`=4'b0011.
  - A=-4, B=-4, add → `res_q`=4'b1000 (-8).
- Held enter: `btn_enter` high for 10 cycles in S_A → exactly one transition to S_B; `dp_a` latched once.
- Clear mid-operation: clear asserted in S_B after A=2 → S_A; `dp_a`=0; `res_valid`=0; a later enter is accepted normally.
- Chain with `CALC_CHAIN_EN`:
  - 1+1=2, then enter → S_B with `dp_a`=3'b010.
  - 3+2=5, then enter → `chain_err`=1 and state S_A.

Source files
------------

// File: rtl/calc_controller.sv
// Sequencing controller for the signed 3-bit add/sub calculator: collects operands A and B plus an
// operation under enter, drives the add_sub datapath, and captures its result. Optional macro: CALC_CHAIN_EN.
module calc_controller #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       sw_val,
    input  logic             sw_op,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [2:0]       dp_a,
    output logic [2:0]       dp_b,
    output logic             dp_m,
    input  logic [3:0]       dp_result,
    output logic [3:0]       res_q,
    output logic             res_valid,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] op_cnt,
    output logic             chain_err
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    logic   btn_enter_q;
    logic   enter_rise;

    assign enter_rise = btn_enter & ~btn_enter_q;

`ifdef CALC_CHAIN_EN
    // A result can be fed back as operand A only if it fits the 3-bit signed range.
    logic chain_ok;
    assign chain_ok = (res_q[3] == res_q[2]);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_A;
            btn_enter_q <= 1'b0;
        end else begin
            state       <= next_state;
            btn_enter_q <= btn_enter;
        end
    end

    always_comb begin
        next_state = state;
        if (btn_clear) begin
            next_state = S_A;
        end else begin
            case (state)
                S_A:    if (enter_rise) next_state = S_B;
                S_B:    if (enter_rise) next_state = S_EXEC;
                S_EXEC: next_state = S_SHOW;
                S_SHOW: begin
                    if (enter_rise) begin
`ifdef CALC_CHAIN_EN
                        next_state = chain_ok ? S_B : S_A;
`else
                        next_state = S_A;
`endif
                    end
                end
                default: next_state = S_A;
            endcase
        end
    end

    always_comb begin
        busy    = (state == S_EXEC);
        state_o = state;
    end

    // Datapath operand and result registers; dp_* only move when entering S_B/S_EXEC or on clear.
    always_ff @(posedge clk) begin
        if (rst || btn_clear) begin
            dp_a      <= '0;
            dp_b      <= '0;
            dp_m      <= 1'b0;
            res_q     <= '0;
            res_valid <= 1'b0;
            op_cnt    <= '0;
        end else begin
            case (state)
                S_A: begin
                    if (enter_rise) begin
                        dp_a      <= sw_val;
                        res_valid <= 1'b0;
                    end
                end
                S_B: begin
                    if (enter_rise) begin
                        dp_b <= sw_val;
                        dp_m <= sw_op;
                    end
                end
                S_EXEC: begin
                    res_q     <= dp_result;
                    res_valid <= 1'b1;
                    op_cnt    <= op_cnt + CNT_W'(1);
                end
                S_SHOW: begin
`ifdef CALC_CHAIN_EN
                    if (enter_rise && chain_ok) begin
                        dp_a      <= res_q[2:0];
                        res_valid <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef CALC_CHAIN_EN
    always_ff @(posedge clk) begin
        if (rst || btn_clear) begin
            chain_err <= 1'b0;
        end else if (enter_rise && state == S_A) begin
            chain_err <= 1'b0;
        end else if (enter_rise && state == S_SHOW && !chain_ok) begin
            chain_err <= 1'b1;
        end
    end
`else
    assign chain_err = 1'b0;
`endif

endmodule

// File: tb/tb_calc_controller.sv
// Directed self-checking bench for calc_controller with a behavioural add_sub datapath.
// Chain behaviour is checked when CALC_CHAIN_EN is defined, otherwise the plain S_SHOW->S_A return.
module tb_calc_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       sw_val;
    logic             sw_op;
    logic             btn_enter;
    logic             btn_clear;
    logic [2:0]       dp_a;
    logic [2:0]       dp_b;
    logic             dp_m;
    logic [3:0]       dp_result;
    logic [3:0]       res_q;
    logic             res_valid;
    logic             busy;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] op_cnt;
    logic             chain_err;

    int               num_checks = 0;
    int               num_errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    calc_controller #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_val    (sw_val),
        .sw_op     (sw_op),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_m      (dp_m),
        .dp_result (dp_result),
        .res_q     (res_q),
        .res_valid (res_valid),
        .busy      (busy),
        .state_o   (state_o),
        .op_cnt    (op_cnt),
        .chain_err (chain_err)
    );

    always #5 clk = ~clk;

    // Behavioural add_sub: sign-extend both operands to 4 bits, add or subtract.
    always_comb begin
        if (dp_m)
            dp_result = {dp_a[2], dp_a} - {dp_b[2], dp_b};
        else
            dp_result = {dp_a[2], dp_a} + {dp_b[2], dp_b};
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enter press: raise enter with the switches set, let one edge sample it, then release.
    task automatic applyStimulus(input logic [2:0] val, input logic op);
        sw_val    = val;
        sw_op     = op;
        btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
    endtask

    task automatic doOp(input logic [2:0] a, input logic [2:0] b, input logic op, input logic [3:0] exp_res);
        applyStimulus(a, 1'b0);
        checkOutput("a_state", state_o, 2'd1);
        checkOutput("a_latch", dp_a, a);
        checkOutput("a_valid_clr", res_valid, 1'b0);
        checkOutput("a_chain_clr", chain_err, 1'b0);
        tick();
        applyStimulus(b, op);
        checkOutput("exec_state", state_o, 2'd2);
        checkOutput("exec_busy", busy, 1'b1);
        checkOutput("b_latch", dp_b, b);
        checkOutput("m_latch", dp_m, op);
        tick();
        exp_cnt = exp_cnt + 1'b1;
        checkOutput("show_state", state_o, 2'd3);
        checkOutput("show_busy", busy, 1'b0);
        checkOutput("res_q", res_q, exp_res);
        checkOutput("res_valid", res_valid, 1'b1);
        checkOutput("op_cnt", op_cnt, exp_cnt);
    endtask

    // Enter in S_SHOW; always finishes with the block back in S_A.
    task automatic leaveShow(input logic [3:0] exp_res);
        applyStimulus(3'd0, 1'b0);
        checkOutput("show_res_held", res_q, exp_res);
`ifdef CALC_CHAIN_EN
        if (exp_res[3] == exp_res[2]) begin
            checkOutput("chain_state", state_o, 2'd1);
            checkOutput("chain_dp_a", dp_a, exp_res[2:0]);
            checkOutput("chain_valid", res_valid, 1'b0);
            tick();
            btn_clear = 1'b1;
            tick();
            btn_clear = 1'b0;
            exp_cnt   = '0;
            checkOutput("chain_clr_state", state_o, 2'd0);
        end else begin
            checkOutput("chain_err_state", state_o, 2'd0);
            checkOutput("chain_err_set", chain_err, 1'b1);
            checkOutput("chain_err_valid", res_valid, 1'b1);
            tick();
        end
`else
        checkOutput("leave_state", state_o, 2'd0);
        checkOutput("leave_valid_held", res_valid, 1'b1);
        checkOutput("leave_chain_err", chain_err, 1'b0);
        tick();
`endif
    endtask

    initial begin
        rst       = 1'b1;
        sw_val    = 3'd0;
        sw_op     = 1'b0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("rst_state", state_o, 2'd0);
        checkOutput("rst_dp_a", dp_a, 3'd0);
        checkOutput("rst_dp_b", dp_b, 3'd0);
        checkOutput("rst_dp_m", dp_m, 1'b0);
        checkOutput("rst_res_q", res_q, 4'd0);
        checkOutput("rst_res_valid", res_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_op_cnt", op_cnt, 4'd0);
        checkOutput("rst_chain_err", chain_err, 1'b0);

        doOp(3'd3, 3'd2, 1'b0, 4'b0101);
        leaveShow(4'b0101);
        doOp(3'd1, 3'b110, 1'b1, 4'b0011);
        leaveShow(4'b0011);
        doOp(3'b100, 3'b100, 1'b0, 4'b1000);
        leaveShow(4'b1000);
        doOp(3'd1, 3'd1, 1'b0, 4'b0010);
        leaveShow(4'b0010);

        // Held enter in S_A: one transition, dp_a latched once.
        sw_val    = 3'd2;
        btn_enter = 1'b1;
        tick();
        checkOutput("held_first_state", state_o, 2'd1);
        checkOutput("held_first_dp_a", dp_a, 3'd2);
        sw_val = 3'd1;
        for (int i = 0; i < 9; i++) tick();
        checkOutput("held_state", state_o, 2'd1);
        checkOutput("held_dp_a", dp_a, 3'd2);
        btn_enter = 1'b0;
        tick();

        // Clear in S_B after A=2.
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
        exp_cnt   = '0;
        checkOutput("clr_state", state_o, 2'd0);
        checkOutput("clr_dp_a", dp_a, 3'd0);
        checkOutput("clr_res_valid", res_valid, 1'b0);
        checkOutput("clr_res_q", res_q, 4'd0);
        checkOutput("clr_op_cnt", op_cnt, 4'd0);
        applyStimulus(3'd1, 1'b0);
        checkOutput("post_clr_state", state_o, 2'd1);
        checkOutput("post_clr_dp_a", dp_a, 3'd1);
        tick();

        // Clear during S_EXEC: no capture, no count.
        applyStimulus(3'd1, 1'b0);
        checkOutput("exec_clr_busy", busy, 1'b1);
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
        checkOutput("exec_clr_state", state_o, 2'd0);
        checkOutput("exec_clr_cnt", op_cnt, 4'd0);
        checkOutput("exec_clr_valid", res_valid, 1'b0);
        checkOutput("exec_clr_res", res_q, 4'd0);

        // Enter held through S_EXEC and S_SHOW yields no further transition.
        applyStimulus(3'd2, 1'b0);
        tick();
        sw_val    = 3'd1;
        sw_op     = 1'b0;
        btn_enter = 1'b1;
        tick();
        tick();
        tick();
        tick();
        exp_cnt = exp_cnt + 1'b1;
        checkOutput("hold_show_state", state_o, 2'd3);
        checkOutput("hold_show_res", res_q, 4'b0011);
        checkOutput("hold_show_cnt", op_cnt, exp_cnt);
        btn_enter = 1'b0;
        tick();
        leaveShow(4'b0011);

        // Counter wrap with the 4-bit counter.
        for (int i = 0; i < 18; i++) begin
            doOp(3'd3, 3'd3, 1'b0, 4'b0110);
            leaveShow(4'b0110);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
